// File: rtl/mul_accum_pkg.sv
// Shared types and defaults for the mul_accum product-stream accumulator.
package mul_accum_pkg;

  localparam int unsigned DefDataW   = 32;
  localparam int unsigned DefAccW    = 64;
  localparam int unsigned DefPeriodW = 16;

  // Controller state encodings
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DELAY = 2'd1;
  localparam logic [1:0] ACCUM = 2'd2;

  typedef enum logic [1:0] {
    StIdle  = IDLE,
    StDelay = DELAY,
    StAccum = ACCUM
  } state_e;

endpackage

// File: rtl/mul_accum_if.sv
// Control/data bundle between the sample producer and the mul_accum block.
interface mul_accum_if #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned PERIOD_W = 16
);
  logic                run;
  logic                running;
  logic [DATA_W-1:0]   in0;
  logic [DATA_W-1:0]   out0;
  logic                done;
  logic [31:0]         delay0;
  logic [PERIOD_W-1:0] period;
  logic [5:0]          shift;

  modport master (
    output run, running, in0, delay0, period, shift,
    input  out0, done
  );

  modport slave (
    input  run, running, in0, delay0, period, shift,
    output out0, done
  );
endinterface

// File: rtl/accum_out_fmt.sv
// Result formatter: arithmetic right shift of the sum, then truncate (default)
// or saturate to DATA_W when MUL_ACCUM_SAT_EN is defined.
module accum_out_fmt #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ACC_W  = 64
) (
  input  logic [ACC_W-1:0]  sum_i,
  input  logic [5:0]        shift_i,
  output logic [DATA_W-1:0] res_o
);

`ifdef MUL_ACCUM_SAT_EN
  localparam logic signed [ACC_W-1:0] SatMax = ACC_W'({1'b0, {(DATA_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SatMin = ~SatMax;

  logic signed [ACC_W-1:0] shifted;

  // Shift then clamp into the signed DATA_W range
  always_comb begin
    shifted = $signed(sum_i) >>> shift_i;
    if (shifted > SatMax) begin
      res_o = DATA_W'(SatMax);
    end else if (shifted < SatMin) begin
      res_o = DATA_W'(SatMin);
    end else begin
      res_o = DATA_W'(shifted);
    end
  end
`else
  // Shift then keep the low DATA_W bits
  always_comb begin
    res_o = DATA_W'($signed(sum_i) >>> shift_i);
  end
`endif

endmodule

// File: rtl/mul_accum.sv
// mul_accum: sums signed samples over a programmable period after a start
// delay, then presents the shifted sum on out0. Optional output saturation
// is selected with MUL_ACCUM_SAT_EN (handled in accum_out_fmt).
module mul_accum
  import mul_accum_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned ACC_W    = DefAccW,
  parameter int unsigned PERIOD_W = DefPeriodW
) (
  input  logic        clk,
  input  logic        rst,
  mul_accum_if.slave  bus
);

  state_e              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d, acc_next, in_ext;
  logic [PERIOD_W-1:0] cnt_q, cnt_d, cnt_last;
  logic [31:0]         dly_q, dly_d;
  logic [DATA_W-1:0]   out0_q, out0_d, fmt_res;
  logic                done_q, done_d;

  // Sample extension, running sum and last-index of the period (0 acts as 1)
  always_comb begin
    in_ext   = {{(ACC_W-DATA_W){bus.in0[DATA_W-1]}}, bus.in0};
    acc_next = (cnt_q == '0) ? in_ext : acc_q + in_ext;
    cnt_last = (bus.period == '0) ? '0 : bus.period - PERIOD_W'(1);
  end

  accum_out_fmt #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_fmt (
    .sum_i  (acc_next),
    .shift_i(bus.shift),
    .res_o  (fmt_res)
  );

  // Next-state: run restarts from anywhere; dropping running aborts the period
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dly_d   = dly_q;
    out0_d  = out0_q;
    done_d  = done_q;
    if (bus.run) begin
      dly_d   = bus.delay0;
      cnt_d   = '0;
      state_d = StDelay;
      done_d  = 1'b0;
    end else if (state_q != StIdle) begin
      if (!bus.running) begin
        state_d = StIdle;
        done_d  = 1'b1;
      end else begin
        if (state_q == StDelay) begin
          if (dly_q != '0) begin
            dly_d = dly_q - 32'd1;
          end else begin
            state_d = StAccum;
          end
        end
        // The cycle that leaves DELAY already carries sample 0
        if (state_q == StAccum || dly_q == '0) begin
          acc_d = acc_next;
          if (cnt_q == cnt_last) begin
            out0_d = fmt_res;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + PERIOD_W'(1);
          end
        end
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      dly_q   <= '0;
      out0_q  <= '0;
      done_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dly_q   <= dly_d;
      out0_q  <= out0_d;
      done_q  <= done_d;
    end
  end

  // Drive outputs
  always_comb begin
    bus.out0 = out0_q;
    bus.done = done_q;
  end

endmodule

// File: tb/tb_mul_accum.sv
// Self-checking bench for mul_accum: directed table, corner sequences and a
// random run compared against a sample-queue reference model.
module tb_mul_accum;

  logic clk = 1'b0;
  logic rst_n;

  mul_accum_if #(.DATA_W(32), .PERIOD_W(16)) bus_if ();

  mul_accum #(
    .DATA_W  (32),
    .ACC_W   (64),
    .PERIOD_W(16)
  ) dut (
    .clk(clk),
    .rst(rst_n),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model: waiting count, then a queue of samples for the period
  bit          m_active;
  int          m_wait;
  int          m_q[$];
  logic [31:0] m_out;
  bit          m_done;

  typedef struct {
    bit          run;
    bit          running;
    logic [31:0] in0;
    logic [31:0] exp_out;
    bit          exp_done;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_fmt(input longint s, input int sh);
    longint r;
    r = s >>> sh;
`ifdef MUL_ACCUM_SAT_EN
    if (r > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (r < -64'sd2147483648) return 32'h8000_0000;
`endif
    return r[31:0];
  endfunction

  task automatic model_edge();
    int p;
    longint s;
    p = (bus_if.period == 0) ? 1 : int'(bus_if.period);
    if (!rst_n) begin
      m_active = 0; m_wait = 0; m_q.delete(); m_out = 0; m_done = 1;
    end else if (bus_if.run) begin
      m_active = 1; m_wait = int'(bus_if.delay0); m_q.delete(); m_done = 0;
    end else if (m_active) begin
      if (!bus_if.running) begin
        m_active = 0; m_done = 1; m_q.delete();
      end else if (m_wait > 0) begin
        m_wait--;
      end else begin
        m_q.push_back(int'(bus_if.in0));
        if (m_q.size() >= p) begin
          s = 0;
          foreach (m_q[i]) s += longint'(m_q[i]);
          m_out = ref_fmt(s, int'(bus_if.shift));
          m_q.delete();
        end
      end
    end
  endtask

  // Called at a negedge: drive, clock, update model, compare on next negedge
  task automatic cycle(input string tag, input bit r, input bit rn, input logic [31:0] d);
    bus_if.run     = r;
    bus_if.running = rn;
    bus_if.in0     = d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk({tag, ".out0"}, bus_if.out0, m_out);
    chk({tag, ".done"}, {31'b0, bus_if.done}, {31'b0, m_done});
  endtask

  initial begin
    logic [31:0] ex4;
    logic [31:0] d;
    bit r, rn;
`ifdef MUL_ACCUM_SAT_EN
    ex4 = 32'h7FFF_FFFF;
`else
    ex4 = 32'hFFFF_FFFE;
`endif
    m_active = 0; m_wait = 0; m_out = 0; m_done = 1;
    rst_n = 1'b0;
    bus_if.run = 1'b1; bus_if.running = 1'b1; bus_if.in0 = 32'd5;
    bus_if.delay0 = 0; bus_if.period = 16'd4; bus_if.shift = 6'd0;
    @(negedge clk);

    // Reset held with run asserted
    cycle("rst", 1, 1, 32'd5);
    cycle("rst", 1, 1, 32'd5);
    chk("rst.out0_zero", bus_if.out0, 32'd0);
    chk("rst.done_one", {31'b0, bus_if.done}, 32'd1);
    rst_n = 1'b1;
    repeat (3) cycle("idle", 0, 1, 32'd9);
    chk("idle.done", {31'b0, bus_if.done}, 32'd1);

    // Directed table: delay0=0, period=4, shift=0, samples 1..8
    tbl[0] = '{1'b1, 1'b1, 32'd0, 32'd0, 1'b0};
    for (int i = 1; i <= 8; i++) begin
      tbl[i] = '{1'b0, 1'b1, 32'(i), (i < 4) ? 32'd0 : (i < 8) ? 32'd10 : 32'd26, 1'b0};
    end
    tbl[9] = '{1'b0, 1'b0, 32'd0, 32'd26, 1'b1};
    for (int i = 0; i < 10; i++) begin
      cycle("tbl", tbl[i].run, tbl[i].running, tbl[i].in0);
      chk($sformatf("tbl[%0d].out0", i), bus_if.out0, tbl[i].exp_out);
      chk($sformatf("tbl[%0d].done", i), {31'b0, bus_if.done}, {31'b0, tbl[i].exp_done});
    end

    // Start delay of 3, period 2, constant -5
    bus_if.delay0 = 3; bus_if.period = 16'd2;
    cycle("dly", 1, 1, 32'hFFFF_FFFB);
    repeat (4) cycle("dly", 0, 1, 32'hFFFF_FFFB);
    chk("dly.not_yet", bus_if.out0, 32'd26);
    repeat (7) cycle("dly", 0, 1, 32'hFFFF_FFFB);
    chk("dly.minus10", bus_if.out0, 32'hFFFF_FFF6);
    cycle("dly", 0, 0, 32'd0);

    // Overflow of DATA_W with and without shift
    bus_if.delay0 = 0; bus_if.period = 16'd2; bus_if.shift = 6'd1;
    cycle("ovf", 1, 1, 32'd0);
    repeat (2) cycle("ovf", 0, 1, 32'h7FFF_FFFF);
    chk("ovf.shift1", bus_if.out0, 32'h7FFF_FFFF);
    bus_if.shift = 6'd0;
    repeat (2) cycle("ovf", 0, 1, 32'h7FFF_FFFF);
    chk("ovf.shift0", bus_if.out0, ex4);

    // Abort after 3 of 4 samples, then restart
    bus_if.period = 16'd4;
    cycle("abrt", 1, 1, 32'd0);
    cycle("abrt", 0, 1, 32'd10);
    cycle("abrt", 0, 1, 32'd20);
    cycle("abrt", 0, 1, 32'd30);
    cycle("abrt", 0, 0, 32'd40);
    chk("abrt.hold", bus_if.out0, ex4);
    chk("abrt.done", {31'b0, bus_if.done}, 32'd1);
    cycle("abrt", 1, 1, 32'd0);
    repeat (4) cycle("abrt", 0, 1, 32'd1);
    chk("abrt.fresh", bus_if.out0, 32'd4);

    // Re-pulse run mid-period
    cycle("rerun", 1, 1, 32'd0);
    cycle("rerun", 0, 1, 32'd100);
    cycle("rerun", 0, 1, 32'd100);
    bus_if.delay0 = 1;
    cycle("rerun", 1, 1, 32'd100);
    cycle("rerun", 0, 1, 32'd999);
    for (int i = 2; i <= 5; i++) cycle("rerun", 0, 1, 32'(i));
    chk("rerun.sum", bus_if.out0, 32'd14);

    // Reset while accumulating, with run asserted
    bus_if.delay0 = 0;
    cycle("mrst", 1, 1, 32'd0);
    cycle("mrst", 0, 1, 32'd7);
    rst_n = 1'b0;
    cycle("mrst", 1, 1, 32'd7);
    chk("mrst.out0", bus_if.out0, 32'd0);
    rst_n = 1'b1;
    cycle("mrst", 0, 1, 32'd7);
    chk("mrst.idle", {31'b0, bus_if.done}, 32'd1);

    // Period 0 behaves as 1
    bus_if.period = 16'd0; bus_if.shift = 6'd2;
    cycle("p1", 1, 1, 32'd0);
    for (int i = 0; i < 6; i++) cycle("p1", 0, 1, $urandom());
    cycle("p1", 0, 0, 32'd0);

    // Random traffic; config only changes alongside a run pulse
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 39) == 0);
      if (r) begin
        bus_if.delay0 = $urandom_range(0, 4);
        bus_if.period = 16'($urandom_range(0, 5));
        bus_if.shift  = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                                     : 6'($urandom_range(0, 3));
      end
      rn = ($urandom_range(0, 49) != 0);
      rst_n = ($urandom_range(0, 299) != 0);
      case ($urandom_range(0, 7))
        0:       d = 32'h7FFF_FFFF;
        1:       d = 32'h8000_0000;
        default: d = $urandom();
      endcase
      cycle("rand", r, rn, d);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
